// File: rtl/hcsr04_level_monitor.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : hcsr04_level_monitor
// Brief    : HC-SR04 ranging engine. It issues periodic trigger pulses and
//            measures echo width with a timeout. It keeps a moving average of
//            the last 2^AVG_LOG2 good samples, and derives a hysteretic
//            level-OK flag and a consecutive-timeout fault flag.
// Revision : 1.0 - initial release
// ============================================================================
module hcsr04_level_monitor #(
  parameter int TRIG_CYCLES    = 500,
  parameter int PERIOD_CYCLES  = 3_000_000,
  parameter int TIMEOUT_CYCLES = 1_500_000,
  parameter int CNT_W          = 22,
  parameter int AVG_LOG2       = 2,
  parameter int TH_ON          = 30000,
  parameter int TH_OFF         = 33000,
  parameter int ERR_LIMIT      = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable_i,
  input  logic             echo_i,
  output logic             trigger_o,
  output logic [CNT_W-1:0] distance_o,
  output logic             valid_o,
  output logic             level_ok_o,
  output logic             timeout_o,
  output logic             fault_o
);

  // --------------------------------------------------------------------------
  // Derived sizes and typed constants
  // --------------------------------------------------------------------------
  localparam int DEPTH  = 1 << AVG_LOG2;
  localparam int SUM_W  = CNT_W + AVG_LOG2;
  localparam int PER_W  = $clog2(PERIOD_CYCLES + 1);
  localparam int TRG_W  = $clog2(TRIG_CYCLES + 1);
  // One phase counter serves the trigger, wait-for-rise and width phases.
  localparam int PH_W   = (CNT_W > TRG_W) ? CNT_W : TRG_W;
  localparam int FILL_W = AVG_LOG2 + 1;
  localparam int ERR_W  = (ERR_LIMIT < 2) ? 1 : $clog2(ERR_LIMIT + 1);

  localparam logic [PH_W-1:0]   C_PH_ONE    = PH_W'(1);
  localparam logic [PH_W-1:0]   C_TRIG_LAST = PH_W'(TRIG_CYCLES - 1);
  localparam logic [PH_W-1:0]   C_TO_LAST   = PH_W'(TIMEOUT_CYCLES - 1);
  localparam logic [PH_W-1:0]   C_TO        = PH_W'(TIMEOUT_CYCLES);
  localparam logic [PER_W-1:0]  C_PER_ONE   = PER_W'(1);
  localparam logic [PER_W-1:0]  C_PER_LAST  = PER_W'(PERIOD_CYCLES - 1);
  localparam logic [FILL_W-1:0] C_FILL_ONE  = FILL_W'(1);
  localparam logic [FILL_W-1:0] C_DEPTH     = FILL_W'(DEPTH);
  localparam logic [ERR_W-1:0]  C_ERR_ONE   = ERR_W'(1);
  localparam logic [ERR_W-1:0]  C_ERR_LIM   = ERR_W'(ERR_LIMIT);
  localparam logic [SUM_W-1:0]  C_TH_ON     = SUM_W'(TH_ON);
  localparam logic [SUM_W-1:0]  C_TH_OFF    = SUM_W'(TH_OFF);

  // FSM encoding
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_TRIG = 3'd1;
  localparam logic [2:0] S_WAIT = 3'd2;
  localparam logic [2:0] S_MEAS = 3'd3;
  localparam logic [2:0] S_HOLD = 3'd4;

  // --------------------------------------------------------------------------
  // Declarations
  // --------------------------------------------------------------------------
  logic [2:0]        state_q, state_d;
  logic [PH_W-1:0]   cnt_q, cnt_d;
  logic [PER_W-1:0]  period_q, period_d;

  logic              echo_meta_q, echo_meta_d;
  logic              echo_s_q, echo_s_d;
  logic              echo_dly_q, echo_dly_d;
  logic              echo_rise, echo_fall;

  logic              good_evt, to_evt;
  logic              good_q, good_d;
  logic [CNT_W-1:0]  sample_q, sample_d;
  logic [CNT_W-1:0]  buf_q [DEPTH];
  logic [CNT_W-1:0]  buf_d [DEPTH];
  logic [SUM_W-1:0]  sum_q, sum_d;
  logic [SUM_W-1:0]  avg_full;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic [ERR_W-1:0]  err_q, err_d;

  logic              trigger_q, trigger_d;
  logic [CNT_W-1:0]  distance_q, distance_d;
  logic              valid_q, valid_d;
  logic              level_q, level_d;
  logic              timeout_q, timeout_d;
  logic              fault_q, fault_d;

  // --------------------------------------------------------------------------
  // Echo synchronizer and edge detect
  // --------------------------------------------------------------------------
  // Shift the asynchronous echo through two stages plus one delayed copy.
  always_comb begin
    echo_meta_d = echo_i;
    echo_s_d    = echo_meta_q;
    echo_dly_d  = echo_s_q;
  end

  // Synchronizer flops.
  always_ff @(posedge clk) begin
    if (!rst) begin
      echo_meta_q <= 1'b0;
      echo_s_q    <= 1'b0;
      echo_dly_q  <= 1'b0;
    end else begin
      echo_meta_q <= echo_meta_d;
      echo_s_q    <= echo_s_d;
      echo_dly_q  <= echo_dly_d;
    end
  end

  // An echo that is already high when WAIT is entered shows no rise, so it is
  // never taken as a measurement start.
  assign echo_rise = echo_s_q & ~echo_dly_q;
  assign echo_fall = ~echo_s_q & echo_dly_q;

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  // State register.
  always_ff @(posedge clk) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (enable_i) state_d = S_TRIG;
      S_TRIG: if (cnt_q == C_TRIG_LAST) state_d = S_WAIT;
      S_WAIT: begin
        if (echo_rise)               state_d = S_MEAS;
        else if (cnt_q == C_TO_LAST) state_d = S_HOLD;
      end
      S_MEAS: begin
        if (echo_fall)          state_d = S_HOLD;
        else if (cnt_q == C_TO) state_d = S_HOLD;
      end
      S_HOLD: if (period_q == C_PER_LAST) state_d = enable_i ? S_TRIG : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output and datapath next values, derived from the current and next state.
  always_comb begin
    // Measurement events
    good_evt = (state_q == S_MEAS) && echo_fall;
    to_evt   = ((state_q == S_WAIT) && !echo_rise && (cnt_q == C_TO_LAST)) ||
               ((state_q == S_MEAS) && !echo_fall && (cnt_q == C_TO));

    // The phase counter restarts on every state change. Entering MEAS starts
    // it at 1, because the rise cycle already had echo_s high.
    cnt_d = '0;
    if ((state_d == state_q) &&
        ((state_q == S_TRIG) || (state_q == S_WAIT) || (state_q == S_MEAS)))
      cnt_d = cnt_q + C_PH_ONE;
    else if ((state_q == S_WAIT) && (state_d == S_MEAS))
      cnt_d = C_PH_ONE;

    // The period counter is zeroed on the trigger-rise edge. It saturates so
    // that HOLD always sees the exit value.
    period_d = period_q;
    if ((state_d == S_TRIG) && (state_q != S_TRIG))
      period_d = '0;
    else if (period_q != C_PER_LAST)
      period_d = period_q + C_PER_ONE;

    // Sample capture stage
    good_d   = good_evt;
    sample_d = good_evt ? cnt_q[CNT_W-1:0] : sample_q;

    // Averaging stage: shift buffer and running sum
    for (int i = 0; i < DEPTH; i++) buf_d[i] = buf_q[i];
    sum_d  = sum_q;
    fill_d = fill_q;
    if (good_q) begin
      buf_d[0] = sample_q;
      for (int i = 1; i < DEPTH; i++) buf_d[i] = buf_q[i-1];
      sum_d = sum_q + SUM_W'(sample_q) - SUM_W'(buf_q[DEPTH-1]);
      if (fill_q != C_DEPTH) fill_d = fill_q + C_FILL_ONE;
    end
    avg_full = sum_d >> AVG_LOG2;

    // Consecutive timeout counter. A good sample clears it.
    err_d = err_q;
    if (good_q)
      err_d = '0;
    else if (to_evt && (err_q != C_ERR_LIM))
      err_d = err_q + C_ERR_ONE;

    // Registered outputs
    trigger_d  = (state_d == S_TRIG);
    timeout_d  = to_evt;
    valid_d    = good_q && (fill_d == C_DEPTH);
    distance_d = valid_d ? avg_full[CNT_W-1:0] : distance_q;

    fault_d = fault_q;
    if (good_q)
      fault_d = 1'b0;
    else if (to_evt && (err_d == C_ERR_LIM))
      fault_d = 1'b1;

    level_d = level_q;
    if (to_evt && (err_d == C_ERR_LIM))
      level_d = 1'b0;
    else if (valid_d) begin
      if (avg_full < C_TH_ON)       level_d = 1'b1;
      else if (avg_full >= C_TH_OFF) level_d = 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // Datapath and output registers
  // --------------------------------------------------------------------------
  // Counters, averaging state and outputs. A reset also wipes a partial fill.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q      <= '0;
      period_q   <= '0;
      good_q     <= 1'b0;
      sample_q   <= '0;
      for (int i = 0; i < DEPTH; i++) buf_q[i] <= '0;
      sum_q      <= '0;
      fill_q     <= '0;
      err_q      <= '0;
      trigger_q  <= 1'b0;
      distance_q <= '0;
      valid_q    <= 1'b0;
      level_q    <= 1'b0;
      timeout_q  <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      period_q   <= period_d;
      good_q     <= good_d;
      sample_q   <= sample_d;
      for (int i = 0; i < DEPTH; i++) buf_q[i] <= buf_d[i];
      sum_q      <= sum_d;
      fill_q     <= fill_d;
      err_q      <= err_d;
      trigger_q  <= trigger_d;
      distance_q <= distance_d;
      valid_q    <= valid_d;
      level_q    <= level_d;
      timeout_q  <= timeout_d;
      fault_q    <= fault_d;
    end
  end

  assign trigger_o  = trigger_q;
  assign distance_o = distance_q;
  assign valid_o    = valid_q;
  assign level_ok_o = level_q;
  assign timeout_o  = timeout_q;
  assign fault_o    = fault_q;

endmodule
`default_nettype wire
